// File: rtl/sbus_frame_decoder_if.sv
// sbus_frame_decoder_if
// Groups the byte stream coming from the S.BUS UART receiver together with
// the decoded frame outputs handed to the servo/PWM and register-map logic.
//   byte_valid/byte_data/byte_pe/byte_fe : receiver -> decoder
//   ch_data, ch17, ch18, frame_lost, failsafe, frame_valid, frame_err,
//   frame_cnt, err_cnt                    : decoder -> consumers
// master = receiver side (drives bytes), slave = the decoder.
interface sbus_frame_decoder_if;
    logic         byte_valid;
    logic [10:0]  byte_data;
    logic         byte_pe;
    logic         byte_fe;

    logic [175:0] ch_data;
    logic         ch17;
    logic         ch18;
    logic         frame_lost;
    logic         failsafe;
    logic         frame_valid;
    logic         frame_err;
    logic [15:0]  frame_cnt;
    logic [15:0]  err_cnt;

    modport master (
        output byte_valid, byte_data, byte_pe, byte_fe,
        input  ch_data, ch17, ch18, frame_lost, failsafe,
               frame_valid, frame_err, frame_cnt, err_cnt
    );

    modport slave (
        input  byte_valid, byte_data, byte_pe, byte_fe,
        output ch_data, ch17, ch18, frame_lost, failsafe,
               frame_valid, frame_err, frame_cnt, err_cnt
    );
endinterface

// File: rtl/sbus_frame_decoder.sv
// sbus_frame_decoder
// Assembles 25-byte S.BUS frames (0x0F header, 22 packed data bytes, flags,
// footer) from the UART byte stream and unpacks sixteen 11-bit channels plus
// the digital channels and status flags. Outputs change only on a complete,
// error-free frame, one clock after the footer strobe.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    slave side of sbus_frame_decoder_if (byte stream in, frame out)
//
// state  | meaning
// SYNC   | lost alignment; wait for a line-idle gap, discard bytes
// IDLE   | gap observed; waiting for a good 0x0F header
// DATA   | unpacking the 22 channel bytes
// FLAGS  | capturing the flags byte into the shadow register
// FOOTER | checking the footer; commit or abort
module sbus_frame_decoder #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int GAP_US   = 500,
    parameter bit SBUS2_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    sbus_frame_decoder_if.slave bus
);
    localparam int GAP_CYCLES = CLK_HZ / 1_000_000 * GAP_US;
    localparam int GW         = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam int DATA_BYTES = 22;

    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        IDLE   = 3'd1,
        DATA   = 3'd2,
        FLAGS  = 3'd3,
        FOOTER = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [GW-1:0]     gap_cnt;
    logic              gap_seen;

    logic [18:0]       acc;
    logic [18:0]       acc_nxt;
    logic [4:0]        bitcnt;
    logic [4:0]        bitcnt_nxt;
    logic [4:0]        idx;
    logic [4:0]        idx_nxt;
    logic [4:0]        bcnt;
    logic [4:0]        bcnt_nxt;

    logic [15:0][10:0] sh_ch;
    logic [3:0]        sh_flags;

    logic              ch_we;
    logic [10:0]       ch_word;
    logic              flags_we;
    logic              commit;
    logic              abort;

    logic              bad;
    logic              footer_ok;
    logic [7:0]        rx_byte;
    logic [18:0]       acc_sum;
    logic [4:0]        cnt_sum;

    // Parity and stop bits are already judged by the receiver (byte_pe/fe).
    wire unused_stop_parity = ^bus.byte_data[10:8];

    assign rx_byte  = bus.byte_data[7:0];
    assign bad      = bus.byte_pe | bus.byte_fe;
    assign gap_seen = (gap_cnt == GW'(GAP_CYCLES));

    // SBUS2 footers are 0x04/0x14/0x24/0x34: low nibble 4, top two bits 0.
    assign footer_ok = (rx_byte == 8'h00) ||
                       (SBUS2_EN && (rx_byte[7:6] == 2'b00) && (rx_byte[3:0] == 4'h4));

    // The accumulator never holds more than 10 pending bits before a byte is
    // merged, so a byte shifted by bitcnt always fits in 19 bits.
    assign acc_sum = acc | (19'(rx_byte) << bitcnt);
    assign cnt_sum = bitcnt + 5'd8;

    always_ff @(posedge clk) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (bus.byte_valid) begin
            gap_cnt <= '0;
        end else if (!gap_seen) begin
            gap_cnt <= gap_cnt + GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // A byte strobe always takes priority over gap_seen in the same cycle.
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        bitcnt_nxt = bitcnt;
        idx_nxt    = idx;
        bcnt_nxt   = bcnt;
        ch_we      = 1'b0;
        ch_word    = acc_sum[10:0];
        flags_we   = 1'b0;
        commit     = 1'b0;
        abort      = 1'b0;

        unique case (state)
            SYNC: begin
                if (!bus.byte_valid && gap_seen) begin
                    state_nxt = IDLE;
                end
            end

            IDLE: begin
                if (bus.byte_valid) begin
                    if (!bad && (rx_byte == 8'h0F)) begin
                        state_nxt  = DATA;
                        acc_nxt    = '0;
                        bitcnt_nxt = '0;
                        idx_nxt    = '0;
                        bcnt_nxt   = '0;
                    end else begin
                        state_nxt = SYNC;
                    end
                end
            end

            DATA: begin
                if (bus.byte_valid) begin
                    if (bad) begin
                        abort     = 1'b1;
                        state_nxt = SYNC;
                    end else begin
                        if (cnt_sum >= 5'd11) begin
                            ch_we      = 1'b1;
                            acc_nxt    = acc_sum >> 11;
                            bitcnt_nxt = cnt_sum - 5'd11;
                            idx_nxt    = idx + 5'd1;
                        end else begin
                            acc_nxt    = acc_sum;
                            bitcnt_nxt = cnt_sum;
                        end
                        bcnt_nxt = bcnt + 5'd1;
                        if (bcnt == 5'(DATA_BYTES - 1)) begin
                            state_nxt = FLAGS;
                        end
                    end
                end else if (gap_seen) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end

            FLAGS: begin
                if (bus.byte_valid) begin
                    if (bad) begin
                        abort     = 1'b1;
                        state_nxt = SYNC;
                    end else begin
                        flags_we  = 1'b1;
                        state_nxt = FOOTER;
                    end
                end else if (gap_seen) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end

            FOOTER: begin
                if (bus.byte_valid) begin
                    if (!bad && footer_ok) begin
                        commit    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        abort     = 1'b1;
                        state_nxt = SYNC;
                    end
                end else if (gap_seen) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = SYNC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            bitcnt   <= '0;
            idx      <= '0;
            bcnt     <= '0;
            sh_ch    <= '0;
            sh_flags <= '0;
        end else begin
            acc    <= acc_nxt;
            bitcnt <= bitcnt_nxt;
            idx    <= idx_nxt;
            bcnt   <= bcnt_nxt;
            if (ch_we) begin
                sh_ch[idx[3:0]] <= ch_word;
            end
            if (flags_we) begin
                sh_flags <= rx_byte[3:0];
            end
        end
    end

    // Visible outputs are only ever loaded from the complete shadow copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ch_data     <= '0;
            bus.ch17        <= 1'b0;
            bus.ch18        <= 1'b0;
            bus.frame_lost  <= 1'b0;
            bus.failsafe    <= 1'b0;
            bus.frame_valid <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.frame_cnt   <= '0;
            bus.err_cnt     <= '0;
        end else begin
            bus.frame_valid <= commit;
            bus.frame_err   <= abort;
            if (commit) begin
                bus.ch_data    <= sh_ch;
                bus.ch17       <= sh_flags[0];
                bus.ch18       <= sh_flags[1];
                bus.frame_lost <= sh_flags[2];
                bus.failsafe   <= sh_flags[3];
                bus.frame_cnt  <= bus.frame_cnt + 16'd1;
            end
            if (abort && (bus.err_cnt != 16'hFFFF)) begin
                bus.err_cnt <= bus.err_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_sbus_frame_decoder.sv
// tb_sbus_frame_decoder
// Drives two decoders (SBUS2 footers enabled / disabled) with the same byte
// stream. A reference model tracks sync, the frame bytes and line-idle time
// per decoder and queues the expected frame_valid / frame_err events; a
// negedge monitor pops and compares whenever a decoder pulses.
module tb_sbus_frame_decoder;
    localparam int CLK_HZ = 1_000_000;
    localparam int GAP_US = 40;
    localparam int GAP    = CLK_HZ / 1_000_000 * GAP_US;

    typedef struct {
        bit           is_valid;
        int           cyc;
        logic [175:0] ch;
        logic [3:0]   fl;
        logic [15:0]  fc;
        logic [15:0]  ec;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        byte_valid;
    logic [10:0] byte_data;
    logic        byte_pe;
    logic        byte_fe;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    sbus_frame_decoder_if bus_a ();
    sbus_frame_decoder_if bus_b ();

    assign bus_a.byte_valid = byte_valid;
    assign bus_a.byte_data  = byte_data;
    assign bus_a.byte_pe    = byte_pe;
    assign bus_a.byte_fe    = byte_fe;
    assign bus_b.byte_valid = byte_valid;
    assign bus_b.byte_data  = byte_data;
    assign bus_b.byte_pe    = byte_pe;
    assign bus_b.byte_fe    = byte_fe;

    sbus_frame_decoder #(.CLK_HZ(CLK_HZ), .GAP_US(GAP_US), .SBUS2_EN(1'b1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    sbus_frame_decoder #(.CLK_HZ(CLK_HZ), .GAP_US(GAP_US), .SBUS2_EN(1'b0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    exp_t         qa[$];
    exp_t         qb[$];
    int           m_last [2];
    bit           m_sync [2];
    bit           m_inf  [2];
    int           m_n    [2];
    logic [7:0]   m_buf  [2][24];
    logic [175:0] m_ch   [2];
    logic [3:0]   m_fl   [2];
    logic [15:0]  m_fc   [2];
    logic [15:0]  m_ec   [2];
    bit           m_sbus2 [2] = '{1'b1, 1'b0};

    task automatic push(input int d, input exp_t e);
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    task automatic model_reset(input int d, input int c);
        m_last[d] = c;
        m_sync[d] = 1'b0;
        m_inf[d]  = 1'b0;
        m_n[d]    = 0;
        m_ch[d]   = '0;
        m_fl[d]   = '0;
        m_fc[d]   = '0;
        m_ec[d]   = '0;
    endtask

    task automatic model_err(input int d, input int c);
        exp_t e;
        if (m_ec[d] != 16'hFFFF) m_ec[d] = m_ec[d] + 16'd1;
        e.is_valid = 1'b0;
        e.cyc = c;
        e.ch = m_ch[d];
        e.fl = m_fl[d];
        e.fc = m_fc[d];
        e.ec = m_ec[d];
        push(d, e);
    endtask

    // The line counts as idle once GAP whole cycles pass with no strobe;
    // that is recognised on the cycle after, unless a byte lands there.
    task automatic model_gap(input int d, input int now);
        if (now >= m_last[d] + GAP + 1) begin
            if (m_inf[d]) begin
                m_inf[d] = 1'b0;
                model_err(d, m_last[d] + GAP + 1);
            end
            m_sync[d] = 1'b1;
        end
    endtask

    task automatic model_byte(input int d, input int c, input logic [7:0] b, input bit bad);
        exp_t e;
        bit   legal;
        model_gap(d, c - 1);
        m_last[d] = c;
        if (!m_sync[d]) begin
            // discarded while unsynchronised
        end else if (!m_inf[d]) begin
            if (!bad && b == 8'h0F) begin
                m_inf[d] = 1'b1;
                m_n[d]   = 0;
            end else begin
                m_sync[d] = 1'b0;
            end
        end else if (bad) begin
            m_inf[d]  = 1'b0;
            m_sync[d] = 1'b0;
            model_err(d, c);
        end else begin
            m_buf[d][m_n[d]] = b;
            m_n[d] = m_n[d] + 1;
            if (m_n[d] == 24) begin
                m_inf[d] = 1'b0;
                legal = (b == 8'h00) ||
                        (m_sbus2[d] && (b == 8'h04 || b == 8'h14 || b == 8'h24 || b == 8'h34));
                if (legal) begin
                    // channels are simply the 176-bit LSB-first data bit stream
                    for (int k = 0; k < 176; k++) m_ch[d][k] = m_buf[d][k / 8][k % 8];
                    m_fl[d] = m_buf[d][22][3:0];
                    m_fc[d] = m_fc[d] + 16'd1;
                    e.is_valid = 1'b1;
                    e.cyc = c;
                    e.ch = m_ch[d];
                    e.fl = m_fl[d];
                    e.fc = m_fc[d];
                    e.ec = m_ec[d];
                    push(d, e);
                end else begin
                    m_sync[d] = 1'b0;
                    model_err(d, c);
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input int d, input logic fv, input logic fe, input logic [175:0] ch,
                       input logic [3:0] fl, input logic [15:0] fc, input logic [15:0] ec);
        exp_t e;
        if (!(fv || fe)) return;
        if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse dut%0d: got valid=%0b err=%0b at cycle %0d, required no pulse",
                     d, fv, fe, cyc);
            return;
        end
        if (d == 0) e = qa.pop_front();
        else        e = qb.pop_front();
        chk($sformatf("kind_dut%0d", d), 256'({fv, fe}), 256'({e.is_valid, !e.is_valid}));
        chk($sformatf("cycle_dut%0d", d), 256'(cyc), 256'(e.cyc));
        chk($sformatf("ch_data_dut%0d", d), 256'(ch), 256'(e.ch));
        chk($sformatf("flags_dut%0d", d), 256'(fl), 256'(e.fl));
        chk($sformatf("frame_cnt_dut%0d", d), 256'(fc), 256'(e.fc));
        chk($sformatf("err_cnt_dut%0d", d), 256'(ec), 256'(e.ec));
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon(0, bus_a.frame_valid, bus_a.frame_err, bus_a.ch_data,
                {bus_a.failsafe, bus_a.frame_lost, bus_a.ch18, bus_a.ch17},
                bus_a.frame_cnt, bus_a.err_cnt);
            mon(1, bus_b.frame_valid, bus_b.frame_err, bus_b.ch_data,
                {bus_b.failsafe, bus_b.frame_lost, bus_b.ch18, bus_b.ch17},
                bus_b.frame_cnt, bus_b.err_cnt);
        end
    end

    // ---------------- stimulus ----------------
    logic [10:0] chv [16];
    logic [7:0]  fr  [25];

    task automatic build(input logic [7:0] flags, input logic [7:0] foot);
        logic [175:0] s;
        for (int n = 0; n < 16; n++) s[11 * n +: 11] = chv[n];
        fr[0] = 8'h0F;
        for (int i = 0; i < 22; i++) fr[1 + i] = s[8 * i +: 8];
        fr[23] = flags;
        fr[24] = foot;
    endtask

    task automatic make_f1();
        for (int n = 0; n < 16; n++) chv[n] = 11'h400;
        chv[0]  = 11'h001;
        chv[1]  = 11'h7FF;
        chv[15] = 11'h3AC;
        build(8'h0C, 8'h00);
    endtask

    task automatic make_rand(input logic [7:0] foot);
        for (int n = 0; n < 16; n++) chv[n] = 11'($urandom_range(0, 2047));
        build(8'($urandom_range(0, 255)), foot);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            model_gap(0, cyc);
            model_gap(1, cyc);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit pe, input bit fe);
        byte_valid = 1'b1;
        byte_data  = {2'b11, ^b, b};
        byte_pe    = pe;
        byte_fe    = fe;
        @(posedge clk);
        #1;
        model_byte(0, cyc, b, pe | fe);
        model_byte(1, cyc, b, pe | fe);
        byte_valid = 1'b0;
        byte_pe    = 1'b0;
        byte_fe    = 1'b0;
    endtask

    task automatic send_frame(input int bad_idx, input bit bad_fe, input bit spaced,
                              input int last_idx, input int long_idx, input int long_len);
        for (int i = 0; i <= last_idx; i++) begin
            send_byte(fr[i], (i == bad_idx) && !bad_fe, (i == bad_idx) && bad_fe);
            if (i < last_idx) begin
                if (i == long_idx)  idle(long_len);
                else if (spaced)    idle(int'($urandom_range(0, 3)));
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset(0, cyc);
        model_reset(1, cyc);
        chk("reset_outputs_a", 256'({bus_a.ch_data, bus_a.ch17, bus_a.ch18, bus_a.frame_lost, bus_a.failsafe,
                                     bus_a.frame_valid, bus_a.frame_err, bus_a.frame_cnt, bus_a.err_cnt}), 256'(0));
        chk("reset_outputs_b", 256'({bus_b.ch_data, bus_b.ch17, bus_b.ch18, bus_b.frame_lost, bus_b.failsafe,
                                     bus_b.frame_valid, bus_b.frame_err, bus_b.frame_cnt, bus_b.err_cnt}), 256'(0));
        chk("reset_no_pending", 256'(qa.size() + qb.size()), 256'(0));
    endtask

    task automatic check_f1(input string tag);
        chk({tag, "_ch0"},  256'(bus_a.ch_data[10:0]),    256'(11'h001));
        chk({tag, "_ch1"},  256'(bus_a.ch_data[21:11]),   256'(11'h7FF));
        chk({tag, "_ch7"},  256'(bus_a.ch_data[87:77]),   256'(11'h400));
        chk({tag, "_ch15"}, 256'(bus_a.ch_data[175:165]), 256'(11'h3AC));
        chk({tag, "_flags"}, 256'({bus_a.failsafe, bus_a.frame_lost, bus_a.ch18, bus_a.ch17}), 256'(4'b1100));
    endtask

    logic [7:0] foots [6] = '{8'h00, 8'h04, 8'h14, 8'h24, 8'h34, 8'h55};

    initial begin
        byte_valid = 1'b0;
        byte_data  = '0;
        byte_pe    = 1'b0;
        byte_fe    = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        do_reset();
        idle(GAP + 5);

        // reference frame, spaced strobes
        make_f1();
        send_frame(-1, 1'b0, 1'b1, 24, -1, 0);
        check_f1("f1");
        chk("f1_frame_cnt", 256'(bus_a.frame_cnt), 256'(16'd1));
        idle(3);

        // parity error on data byte 5, then a header with no gap
        send_frame(5, 1'b0, 1'b1, 24, -1, 0);
        chk("pe_err_cnt", 256'(bus_a.err_cnt), 256'(16'd1));
        check_f1("pe_hold");
        idle(2);
        send_byte(8'h0F, 1'b0, 1'b0);
        idle(GAP + 3);
        make_rand(8'h00);
        send_frame(-1, 1'b0, 1'b1, 24, -1, 0);
        chk("after_pe_frame_cnt", 256'(bus_a.frame_cnt), 256'(16'd2));
        idle(GAP + 3);

        // stall after data byte 10, then a full frame right away
        make_rand(8'h00);
        send_frame(-1, 1'b0, 1'b1, 10, -1, 0);
        idle(2 * GAP);
        make_rand(8'h00);
        send_frame(-1, 1'b0, 1'b1, 24, -1, 0);
        idle(GAP + 2);

        // SBUS2 footer: accepted by dut_a only
        make_rand(8'h14);
        send_frame(-1, 1'b0, 1'b1, 24, -1, 0);
        idle(GAP + 2);

        // illegal footer, then a whole frame with no preceding gap
        make_rand(8'h55);
        send_frame(-1, 1'b0, 1'b1, 24, -1, 0);
        idle(1);
        make_f1();
        send_frame(-1, 1'b0, 1'b1, 24, -1, 0);
        idle(GAP + 2);

        // inter-byte idle of exactly GAP (byte wins), then GAP+1 (timeout)
        make_rand(8'h00);
        send_frame(-1, 1'b0, 1'b1, 24, 7, GAP);
        idle(3);
        make_rand(8'h00);
        send_frame(-1, 1'b0, 1'b1, 24, 7, GAP + 1);
        idle(GAP + 2);

        // back-to-back strobes for the reference frame
        make_f1();
        send_frame(-1, 1'b0, 1'b0, 24, -1, 0);
        check_f1("b2b");
        idle(GAP + 2);

        // randomized frames: footers, bad bytes, spacing and gaps
        for (int f = 0; f < 14; f++) begin
            int bad_idx;
            int g;
            make_rand(foots[$urandom_range(0, 5)]);
            bad_idx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 24)) : -1;
            send_frame(bad_idx, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24, -1, 0);
            g = int'($urandom_range(0, 3));
            idle(g == 0 ? 2 : (g == 1 ? GAP : (g == 2 ? GAP + 1 : GAP + 5)));
        end

        // reset at data byte 12, then recovery
        idle(GAP + 2);
        make_rand(8'h00);
        send_frame(-1, 1'b0, 1'b1, 12, -1, 0);
        do_reset();
        idle(GAP + 5);
        make_rand(8'h00);
        send_frame(-1, 1'b0, 1'b1, 24, -1, 0);
        chk("post_reset_frame_cnt", 256'(bus_a.frame_cnt), 256'(16'd1));

        idle(GAP + 5);
        chk("drain_a", 256'(qa.size()), 256'(0));
        chk("drain_b", 256'(qb.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
